// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the word-serial adder.
// The state encoding is fixed so that downstream debug tools can decode it.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int total_width(input int dw, input int nw);
        return dw * nw;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// WIDTH-bit adder slice with carry in and carry out.
// The word-serial sequencer reuses this one slice for every word.
module full_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum   = total[WIDTH-1:0];
    assign cout  = total[WIDTH];

endmodule

// File: rtl/word_serial_adder.sv
// Wide adder that walks the operands one word per cycle, LSW first,
// through a single full_adder slice with a registered inter-word carry.
module word_serial_adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_WORDS  = 4,
    localparam int TOTAL_WIDTH = total_width(DATA_WIDTH, NUM_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic [TOTAL_WIDTH-1:0] A,
    input  logic [TOTAL_WIDTH-1:0] B,
    input  logic                   Carry_in,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [TOTAL_WIDTH-1:0] Sum,
    output logic                   Carry_out,
    output logic                   Busy
);

    localparam int IW = idx_width(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    state_t                 state;
    logic [TOTAL_WIDTH-1:0] a_reg;
    logic [TOTAL_WIDTH-1:0] b_reg;
    logic                   carry;
    logic [IW-1:0]          idx;

    logic [DATA_WIDTH-1:0]  a_word;
    logic [DATA_WIDTH-1:0]  b_word;
    logic [DATA_WIDTH-1:0]  s_word;
    logic                   c_word;

    assign a_word = a_reg[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
    assign b_word = b_reg[int'(idx) * DATA_WIDTH +: DATA_WIDTH];

    full_adder #(
        .WIDTH(DATA_WIDTH)
    ) u_fa (
        .a   (a_word),
        .b   (b_word),
        .cin (carry),
        .sum (s_word),
        .cout(c_word)
    );

    assign In_ready = (state == IDLE);
    assign Busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            Sum       <= '0;
            Carry_out <= 1'b0;
            Out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (In_valid) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= Carry_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    Sum[int'(idx) * DATA_WIDTH +: DATA_WIDTH] <= s_word;
                    carry <= c_word;
                    // Index parks on the last word instead of wrapping.
                    if (idx == LAST) begin
                        Carry_out <= c_word;
                        Out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        Out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_serial_adder.sv
// Randomized and directed bench for word_serial_adder (4x4 and 8x1 builds)
// against an arithmetic reference computed from the operands.
module tb_word_serial_adder;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_valid, In_ready, Carry_in;
    logic        Out_valid, Out_ready, Carry_out, Busy;
    logic [15:0] A, B, Sum;

    logic        In_valid_1, In_ready_1, Carry_in_1;
    logic        Out_valid_1, Out_ready_1, Carry_out_1, Busy_1;
    logic [7:0]  A_1, B_1, Sum_1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_log[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (In_valid && In_ready) acc_log.push_back(cyc);
    end

    word_serial_adder #(.DATA_WIDTH(4), .NUM_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .In_valid(In_valid), .In_ready(In_ready),
        .A(A), .B(B), .Carry_in(Carry_in),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Sum(Sum), .Carry_out(Carry_out), .Busy(Busy)
    );

    word_serial_adder #(.DATA_WIDTH(8), .NUM_WORDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .In_valid(In_valid_1), .In_ready(In_ready_1),
        .A(A_1), .B(B_1), .Carry_in(Carry_in_1),
        .Out_valid(Out_valid_1), .Out_ready(Out_ready_1),
        .Sum(Sum_1), .Carry_out(Carry_out_1), .Busy(Busy_1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 4x4 build; poke drives a rival request
    // while the result is parked, which must be ignored.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int hold, input bit poke);
        logic [16:0] ref_sum;
        int w;
        int lat;
        ref_sum = {1'b0, a} + {1'b0, b} + 17'(cin);
        w = 0;
        while (!In_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_pre", In_ready, 1);
        In_valid = 1'b1;
        A = a;
        B = b;
        Carry_in = cin;
        tick();
        In_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        Carry_in = 1'($urandom);
        lat = 0;
        while (!Out_valid && lat < 20) begin
            check("busy_run", Busy, 1);
            check("in_ready_run", In_ready, 0);
            tick();
            lat++;
        end
        check("latency", lat, NW);
        check("sum", Sum, ref_sum[15:0]);
        check("carry_out", Carry_out, ref_sum[16]);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                In_valid = 1'b1;
                A = 16'hAAAA;
            end
            tick();
            check("hold_valid", Out_valid, 1);
            check("hold_sum", Sum, ref_sum[15:0]);
            check("hold_cout", Carry_out, ref_sum[16]);
            check("hold_in_ready", In_ready, 0);
        end
        In_valid = 1'b0;
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        check("idle_after", {29'd0, Out_valid, In_ready, Busy}, 32'b010);
        if (poke) begin
            tick();
            check("poke_ignored", Busy, 0);
        end
    endtask

    task automatic run_op1(input logic [7:0] a, input logic [7:0] b,
                           input logic cin);
        logic [8:0] ref_sum;
        int lat;
        ref_sum = {1'b0, a} + {1'b0, b} + 9'(cin);
        check("w1_in_ready", In_ready_1, 1);
        In_valid_1 = 1'b1;
        A_1 = a;
        B_1 = b;
        Carry_in_1 = cin;
        tick();
        In_valid_1 = 1'b0;
        lat = 0;
        while (!Out_valid_1 && lat < 20) begin
            tick();
            lat++;
        end
        check("w1_latency", lat, 1);
        check("w1_sum", Sum_1, ref_sum[7:0]);
        check("w1_cout", Carry_out_1, ref_sum[8]);
        Out_ready_1 = 1'b1;
        tick();
        Out_ready_1 = 1'b0;
        check("w1_idle", In_ready_1, 1);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        In_valid = 0; A = 0; B = 0; Carry_in = 0; Out_ready = 0;
        In_valid_1 = 0; A_1 = 0; B_1 = 0; Carry_in_1 = 0; Out_ready_1 = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", Out_valid, 0);
        check("rst_sum", Sum, 0);
        check("rst_cout", Carry_out, 0);
        check("rst_in_ready", In_ready, 1);
        check("rst_busy", Busy, 0);
        check("rst_w1", {Out_valid_1, In_ready_1, Busy_1}, 3'b010);

        run_op(16'h00FF, 16'h0001, 1'b0, 0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 0);
        run_op(16'h1234, 16'h4321, 1'b0, 10, 1);

        // Reset in the second RUN cycle discards the operation.
        In_valid = 1'b1;
        A = 16'hFFFF;
        B = 16'h0001;
        Carry_in = 1'b0;
        tick();
        In_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", Out_valid, 0);
        check("mid_rst_sum", Sum, 0);
        check("mid_rst_cout", Carry_out, 0);
        check("mid_rst_in_ready", In_ready, 1);
        run_op(16'h0001, 16'h0001, 1'b0, 0, 0);

        // Reset while a result is parked in DONE.
        In_valid = 1'b1;
        A = 16'h8001;
        B = 16'h8001;
        tick();
        In_valid = 1'b0;
        repeat (6) tick();
        check("done_parked", Out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("done_rst", {28'd0, Out_valid, In_ready, Busy, Carry_out}, 32'b0100);
        check("done_rst_sum", Sum, 0);

        // Back-to-back with In_valid and Out_ready held high.
        acc_log.delete();
        Out_ready = 1'b1;
        In_valid = 1'b1;
        A = 16'h0001;
        B = 16'h0002;
        Carry_in = 1'b0;
        tick();
        A = 16'h8000;
        B = 16'h8000;
        w = 0;
        while (!Out_valid && w < 20) begin tick(); w++; end
        check("b2b_sum0", Sum, 16'h0003);
        check("b2b_cout0", Carry_out, 0);
        tick();
        w = 0;
        while (!Out_valid && w < 20) begin tick(); w++; end
        In_valid = 1'b0;
        check("b2b_sum1", Sum, 16'h0000);
        check("b2b_cout1", Carry_out, 1);
        tick();
        Out_ready = 1'b0;
        check("b2b_accepts", acc_log.size(), 2);
        if (acc_log.size() >= 2)
            check("b2b_period", acc_log[1] - acc_log[0], NW + 2);

        for (int i = 0; i < 40; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 0);

        run_op1(8'hF0, 8'h20, 1'b0);
        run_op1(8'hFF, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++)
            run_op1(8'($urandom), 8'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
